gray_counter_n: RTL

Parametrised successor to the 3-bit Gray-code counter used in the P1 exercises. Holds a WIDTH-bit count and presents it in Gray code. Adds:
- up/down counting
- synchronous load of a Gray-coded value
- optional saturation instead of wrap
- separate sticky overflow and underflow flags
- a one-cycle wrap pulse

Sits standalone in P1 or as a pointer generator for later FIFO/clock-crossing work. With WIDTH=3, Up=1, Load=0 and SATURATE=0 it is a drop-in superset of the 3-bit counter.

---
 rtl/gray_counter_n.sv | 94 +++++++++
 1 files changed

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with synchronous load, optional
// saturation, sticky overflow/underflow flags and a one-cycle wrap pulse.
module gray_counter_n #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] load_bin;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wrap_q, wrap_d;

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(LoadVal >> i);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the if/else tree can leave it unassigned and infer a latch.
        b_d    = b_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        wrap_d = 1'b0;

        if (Load) begin
            b_d = load_bin;
        end else if (En) begin
            if (Up) begin
                if (b_q == MAX_VAL) begin
                    ovf_d  = 1'b1;
                    wrap_d = 1'b1;
                    if (!SATURATE) b_d = '0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end else begin
                if (b_q == '0) begin
                    udf_d  = 1'b1;
                    wrap_d = 1'b1;
                    if (!SATURATE) b_d = MAX_VAL;
                end else begin
                    b_d = b_q - 1'b1;
                end
            end
        end
    end

    // Gray output is registered from the next binary value so both outputs
    // change on the same edge and no input reaches an output combinationally.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (Reset) begin
            b_q    <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            gray_q <= b_d ^ (b_d >> 1);
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            wrap_q <= wrap_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = b_q;
    assign Overflow  = ovf_q;
    assign Underflow = udf_q;
    assign Wrap      = wrap_q;

endmodule
